// File: rtl/adder_arbiter_pkg.sv
// Shared constants, state encoding and response payload for adder_arbiter.
package adder_arbiter_pkg;

  localparam int unsigned PTR_W   = 3;   // round-robin pointer / owner index width
  localparam int unsigned OP_W    = 16;  // adder operand width
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

  // Registered adder result.
  typedef struct packed {
    logic            cout;
    logic [OP_W-1:0] sum;
  } add_rsp_t;

  // Increment an index modulo nreq.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p,
                                               input int unsigned       nreq);
    if (32'(p) + 32'd1 >= nreq) return '0;
    return p + PTR_W'(1);
  endfunction

endpackage

// File: rtl/adder_16_bit.sv
// 16-bit ripple/behavioural adder shared by the datapath requesters.
//   A, B : operands
//   Cin  : carry-in
//   S    : sum
//   Cout : carry-out
module adder_16_bit (
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout
);

  assign {Cout, S} = 17'(A) + 17'(B) + 17'(Cin);

endmodule

// File: rtl/adder_arbiter_rr_pick.sv
// Combinational round-robin priority select.
//   req : request vector
//   ptr : index with highest priority this cycle
//   gnt : one-hot (or zero) grant
//   idx : index of the granted requester (0 when none)
module adder_arbiter_rr_pick
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [PTR_W-1:0] idx
);

  logic found;

  // Two ascending passes: indices at/above ptr first, then the wrapped ones below it.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (PTR_W'(i) >= ptr)) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = PTR_W'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && req[i] && (PTR_W'(i) < ptr)) begin
        found  = 1'b1;
        gnt[i] = 1'b1;
        idx    = PTR_W'(i);
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one adder_16_bit between NREQ requesters.
// One add per cycle; a requester may lock the adder and chain the stored carry
// for multi-word additions.
//   CLK, RST      : clock, asynchronous active-high reset
//   REQ/LOCK/CHAIN/CIN : per-requester request, lock, carry-chain select, carry-in
//   A, B          : packed operands, requester i at [16i+15:16i]
//   GNT           : combinational one-hot grant (operation consumed this cycle)
//   RSP_VALID     : registered one-hot owner of S/COUT
//   S, COUT       : registered sum and carry-out
//   BUSY          : high while the adder is locked
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] LOCK,
  input  logic [NREQ-1:0] CHAIN,
  input  logic [NREQ-1:0] CIN,
  input  logic [NREQ*W-1:0] A,
  input  logic [NREQ*W-1:0] B,
  output logic [NREQ-1:0] GNT,
  output logic [NREQ-1:0] RSP_VALID,
  output logic [W-1:0]    S,
  output logic            COUT,
  output logic            BUSY
);

  if (W != OP_W) begin : g_bad_w
    $error("adder_arbiter: W must be 16");
  end
  if (NREQ < 2 || NREQ > MAX_REQ) begin : g_bad_nreq
    $error("adder_arbiter: NREQ must be 2..8");
  end

  arb_state_t       state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] owner;
  logic             carry;
  logic [NREQ-1:0]  rsp_valid_q;
  add_rsp_t         rsp_q;

  logic [NREQ-1:0]  pick_gnt;
  logic [PTR_W-1:0] pick_idx;
  logic [NREQ-1:0]  own_oh;
  logic [NREQ-1:0]  gnt_int;
  logic             grant;
  logic [W-1:0]     a_sel;
  logic [W-1:0]     b_sel;
  logic             cin_sel;
  logic             lock_sel;
  logic             chain_sel;
  logic             add_cin;
  logic [OP_W-1:0]  add_sum;
  logic             add_cout;

  adder_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (REQ),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Grant selection and AND-OR operand mux in front of the shared adder.
  always_comb begin
    own_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      own_oh[i] = (owner == PTR_W'(i));
    end

    gnt_int = (state == ST_LOCKED) ? (own_oh & REQ) : pick_gnt;
    grant   = |gnt_int;

    a_sel     = '0;
    b_sel     = '0;
    cin_sel   = 1'b0;
    lock_sel  = 1'b0;
    chain_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_int[i]) begin
        a_sel     = A[i*W +: W];
        b_sel     = B[i*W +: W];
        cin_sel   = CIN[i];
        lock_sel  = LOCK[i];
        chain_sel = CHAIN[i];
      end
    end

    // Stored carry is only honoured while locked.
    add_cin = (state == ST_LOCKED && chain_sel) ? carry : cin_sel;
  end

  adder_16_bit u_add (
    .A    (a_sel),
    .B    (b_sel),
    .Cin  (add_cin),
    .S    (add_sum),
    .Cout (add_cout)
  );

  // Arbitration state, carry and registered response.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= ST_ARB;
      ptr         <= '0;
      owner       <= '0;
      carry       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_q       <= '0;
    end else begin
      rsp_valid_q <= gnt_int;
      if (grant) begin
        rsp_q <= '{cout: add_cout, sum: add_sum};
        carry <= add_cout;
      end
      case (state)
        ST_ARB: begin
          if (grant) begin
            if (lock_sel) begin
              owner <= pick_idx;
              state <= ST_LOCKED;
            end else begin
              ptr <= ptr_inc(pick_idx, NREQ);
            end
          end
        end
        ST_LOCKED: begin
          // Release on an unlocked grant or when the owner stops requesting.
          if (!(grant && lock_sel)) begin
            state <= ST_ARB;
            ptr   <= ptr_inc(owner, NREQ);
          end
        end
        default: state <= ST_ARB;
      endcase
    end
  end

  assign GNT       = RST ? '0 : gnt_int;
  assign RSP_VALID = rsp_valid_q;
  assign S         = rsp_q.sum;
  assign COUT      = rsp_q.cout;
  assign BUSY      = (state == ST_LOCKED);

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter and sequencer that shares one `adder_16_bit` instance between up to eight requesters in the single-cycle RISC datapath (PC incrementer, branch-target unit, ALU extension, address generator). It issues one add per clock and registers the result. A requester can lock the adder for consecutive cycles and chain the stored carry, which gives multi-word (32/48-bit) additions.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters. Legal range 2..8. Pointer wraps modulo `NREQ`.
- `W`, default 16: operand width. Fixed at 16 by `adder_16_bit`; any other value is illegal.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `REQ` in NREQ: request per requester.
- `LOCK` in NREQ: keep the grant after this operation.
- `CHAIN` in NREQ: use the stored carry instead of `CIN` (valid only while locked).
- `CIN` in NREQ: carry-in per requester.
- `A` in NREQ*16: operand A. Requester i occupies bits [16i+15:16i].
- `B` in NREQ*16: operand B, same packing as `A`.
- `GNT` out NREQ: one-hot or zero. Combinational. The operation is consumed in the cycle `GNT` is high.
- `RSP_VALID` out NREQ: one-hot, registered. Marks which requester owns `S`/`COUT`.
- `S` out 16: registered sum.
- `COUT` out 1: registered carry-out.
- `BUSY` out 1: high while in LOCKED.

## Operation
- **State register:** {ARB, LOCKED}, plus `PTR` (3 b), `OWNER` (3 b) and `CARRY` (1 b).
- **ARB state:**
  - Grant the first asserted `REQ[i]` scanning from `PTR` upward, modulo `NREQ`.
  - On a grant with `LOCK[i]`=0: set `PTR` to i+1 mod `NREQ`.
  - On a grant with `LOCK[i]`=1: set `OWNER` to i and go to LOCKED. `PTR` is unchanged.
  - `CHAIN` is ignored in ARB; carry-in is `CIN[i]`.
- **LOCKED state:**
  - `GNT` is only ever `GNT[OWNER]`, and only when `REQ[OWNER]`=1. All other requests stall.
  - Carry-in is `CARRY` if `CHAIN[OWNER]`=1, else `CIN[OWNER]`.
  - Grant with `LOCK`=1: stay in LOCKED.
  - Grant with `LOCK`=0: return to ARB and set `PTR` to `OWNER`+1.
  - `REQ[OWNER]`=0: no grant this cycle; return to ARB next cycle and set `PTR` to `OWNER`+1.
- **On every grant, registered at the clock edge:**
  - `S` and `COUT` take the adder outputs.
  - `CARRY` takes the adder carry-out.
  - `RSP_VALID` takes the grant one-hot.
- **No grant:** `RSP_VALID` becomes 0. `S`, `COUT` and `CARRY` hold their values.
- **Arithmetic:** {`COUT`,`S`} = A + B + cin, modulo 2^17. Unsigned; no overflow flag.
- **Requester rules:**
  - Hold `A`, `B`, `CIN`, `LOCK` and `CHAIN` stable while `REQ`=1 and `GNT`=0.
  - Dropping `REQ` before a grant is legal.
- **Reset (asynchronous, any time, including mid-lock):**
  - State = ARB, `PTR`=0, `OWNER`=0, `CARRY`=0.
  - `RSP_VALID`=0, `S`=0, `COUT`=0, `BUSY`=0.
  - `GNT` is forced to 0 while `RST`=1.
  - Any in-flight response is discarded.

## Timing
- Grant latency is 0 cycles: `GNT` is high in the same cycle as `REQ` when the adder is free.
- Result latency is 1 cycle: `RSP_VALID`/`S`/`COUT` are valid for exactly the cycle after the grant.
- Throughput is one operation per cycle. Back-to-back grants to different requesters are allowed in ARB.
- Fairness: with all requests held, each requester waits at most `NREQ`-1 cycles, plus any lock duration.
- The critical path is `REQ` → priority pick → operand mux → `adder_16_bit` → output register. It must close in one cycle.

## Structure
- Shared include `adder_arb_defs.vh` holds:
  - state encodings `ST_ARB`=1'b0 and `ST_LOCKED`=1'b1;
  - the pointer width constant (3);
  - the operand width constant (16).
- Sub-module `rr_pick`: combinational round-robin priority select (`REQ`, `PTR` → one-hot grant plus index).
- The adder is the existing `adder_16_bit` (ports A, B, Cin, S, Cout), instantiated once. Operand and carry-in muxing sit in front of it.

## Test plan
- **Single request:** `REQ`=0001, A0=0x0012, B0=0x0034, CIN0=0 → `GNT`=0001 in the same cycle; next cycle `RSP_VALID`=0001, `S`=0x0046, `COUT`=0.
- **Fair rotation:** `REQ`=1111 held for 5 cycles → `GNT` sequence 0001, 0010, 0100, 1000, 0001; `RSP_VALID` trails by one cycle.
- **32-bit chained add with a competing request (`REQ[2]` held throughout):**
  - Cycle 1: req1 with LOCK=1, A=0xFFFF, B=0x0001 → `S`=0x0000, `COUT`=1, `BUSY`=1.
  - Cycle 2: req1 with LOCK=0, CHAIN=1, A=0x0001, B=0x0000, CIN=0 → `S`=0x0002.
  - `GNT[2]` is first asserted in the cycle after release.
- **Full carry:** A=0x8000, B=0x8000, CIN=1 → `S`=0x0001, `COUT`=1. Then A=0x00F0, B=0x00DE, CIN=0 → `S`=0x01CE, `COUT`=0.
- **CHAIN ignored in ARB:** after an op leaving `CARRY`=1, req3 unlocked with CHAIN=1, CIN=0, A=0x0005, B=0x0003 → `S`=0x0008.
- **Reset mid-lock:** lock to req0, assert `RST` for 1 cycle while `REQ`=1001 → all outputs 0 immediately; after release `GNT`=0001 (`PTR`=0), then 1000.
